// File: rtl/pmod_axi_rd_arb.sv
// rtl/pmod_axi_rd_arb.sv - two-requester round-robin AXI read arbiter, one burst in flight
module pmod_axi_rd_arb #(
  parameter int DW = 64
) (
  input  logic          M_AXI_ACLK,
  input  logic          M_AXI_ARESET,
  input  logic          S0_ARVALID,
  input  logic [31:0]   S0_ARADDR,
  input  logic [7:0]    S0_ARLEN,
  output logic          S0_ARREADY,
  output logic          S0_RVALID,
  input  logic          S0_RREADY,
  input  logic          S1_ARVALID,
  input  logic [31:0]   S1_ARADDR,
  input  logic [7:0]    S1_ARLEN,
  output logic          S1_ARREADY,
  output logic          S1_RVALID,
  input  logic          S1_RREADY,
  output logic [DW-1:0] S_RDATA,
  output logic          S_RLAST,
  output logic [31:0]   M_AXI_ARADDR,
  output logic [7:0]    M_AXI_ARLEN,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [DW-1:0] M_AXI_RDATA,
  input  logic          M_AXI_RLAST,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_srv, last_srv_nxt;
  logic   arvalid_q, arvalid_nxt;
  logic   in_addr, in_data;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last_srv  <= 1'b1;
      arvalid_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last_srv  <= last_srv_nxt;
      arvalid_q <= arvalid_nxt;
    end
  end

  // A tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    last_srv_nxt = last_srv;
    arvalid_nxt  = arvalid_q;
    case (state)
      IDLE: begin
        if (S0_ARVALID | S1_ARVALID) begin
          grant_nxt   = (S0_ARVALID & S1_ARVALID) ? ~last_srv : S1_ARVALID;
          state_nxt   = ADDR;
          arvalid_nxt = 1'b1;
        end
      end
      ADDR: begin
        if (arvalid_q & M_AXI_ARREADY) begin
          state_nxt   = DATA;
          arvalid_nxt = 1'b0;
        end
      end
      DATA: begin
        if (M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST) begin
          state_nxt    = IDLE;
          last_srv_nxt = grant;
        end
      end
      default: begin
        state_nxt   = IDLE;
        arvalid_nxt = 1'b0;
      end
    endcase
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = grant ? S1_ARADDR : S0_ARADDR;
  assign M_AXI_ARLEN   = grant ? S1_ARLEN  : S0_ARLEN;

  assign S0_ARREADY = in_addr & ~grant & M_AXI_ARREADY;
  assign S1_ARREADY = in_addr &  grant & M_AXI_ARREADY;

  // Downstream beats outside DATA are never acknowledged nor forwarded.
  assign S0_RVALID    = in_data & ~grant & M_AXI_RVALID;
  assign S1_RVALID    = in_data &  grant & M_AXI_RVALID;
  assign M_AXI_RREADY = in_data & (grant ? S1_RREADY : S0_RREADY);

  assign S_RDATA = M_AXI_RDATA;
  assign S_RLAST = M_AXI_RLAST;

endmodule

// File: tb/tb_pmod_axi_rd_arb.sv
// tb/tb_pmod_axi_rd_arb.sv - self-checking bench for pmod_axi_rd_arb
module tb_pmod_axi_rd_arb;

  logic        M_AXI_ACLK, M_AXI_ARESET;
  logic        S0_ARVALID, S0_ARREADY, S0_RVALID, S0_RREADY;
  logic [31:0] S0_ARADDR;
  logic [7:0]  S0_ARLEN;
  logic        S1_ARVALID, S1_ARREADY, S1_RVALID, S1_RREADY;
  logic [31:0] S1_ARADDR;
  logic [7:0]  S1_ARLEN;
  logic [63:0] S_RDATA;
  logic        S_RLAST;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  pmod_axi_rd_arb #(.DW(64)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
    .S0_ARVALID(S0_ARVALID), .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN),
    .S0_ARREADY(S0_ARREADY), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARVALID(S1_ARVALID), .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN),
    .S1_ARREADY(S1_ARREADY), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .S_RDATA(S_RDATA), .S_RLAST(S_RLAST),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    M_AXI_ACLK = 1'b0;
    forever #5 M_AXI_ACLK = ~M_AXI_ACLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no burst, 1 = address offered, 2 = beats flowing.
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_last  = 1;
  int          beats0 = 0, beats1 = 0;
  logic [63:0] last_data0 = '0;
  int          g_log[$];
  logic [31:0] a_log[$];

  always @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      m_phase = 0;
      m_owner = 0;
      m_last  = 1;
    end else begin
      case (m_phase)
        0: if (S0_ARVALID || S1_ARVALID) begin
             if (S0_ARVALID && S1_ARVALID) m_owner = 1 - m_last;
             else                          m_owner = S1_ARVALID ? 1 : 0;
             m_phase = 1;
             g_log.push_back(m_owner);
             a_log.push_back(m_owner == 1 ? S1_ARADDR : S0_ARADDR);
           end
        1: if (M_AXI_ARREADY) m_phase = 2;
        default: if (M_AXI_RVALID && (m_owner == 1 ? S1_RREADY : S0_RREADY)) begin
             if (m_owner == 1) beats1++;
             else begin beats0++; last_data0 = M_AXI_RDATA; end
             if (M_AXI_RLAST) begin m_phase = 0; m_last = m_owner; end
           end
      endcase
    end
  end

  always @(negedge M_AXI_ACLK) begin
    bit in_a, in_d, own1;
    in_a = (m_phase == 1);
    in_d = (m_phase == 2);
    own1 = (m_owner == 1);
    chk("m_arvalid", M_AXI_ARVALID, in_a);
    if (in_a) begin
      chk("m_araddr", M_AXI_ARADDR, own1 ? S1_ARADDR : S0_ARADDR);
      chk("m_arlen", M_AXI_ARLEN, own1 ? S1_ARLEN : S0_ARLEN);
    end
    chk("s0_arready", S0_ARREADY, in_a && !own1 && M_AXI_ARREADY);
    chk("s1_arready", S1_ARREADY, in_a && own1 && M_AXI_ARREADY);
    chk("s0_rvalid", S0_RVALID, in_d && !own1 && M_AXI_RVALID);
    chk("s1_rvalid", S1_RVALID, in_d && own1 && M_AXI_RVALID);
    chk("m_rready", M_AXI_RREADY, in_d && (own1 ? S1_RREADY : S0_RREADY));
    chk("s_rdata", S_RDATA, M_AXI_RDATA);
    chk("s_rlast", S_RLAST, M_AXI_RLAST);
  end

  // Downstream slave: accept the offered address after ar_delay cycles, then return ARLEN+1 beats.
  task automatic serve(input int ar_delay, input bit toggle, input logic [63:0] dbase, output int lat);
    int n, who, c, b;
    bit rr;
    lat = 0;
    while (M_AXI_ARVALID !== 1'b1 && lat < 30) begin
      @(posedge M_AXI_ACLK); #1;
      lat++;
    end
    if (lat >= 30) chk("arvalid_timeout", lat, 0);
    repeat (ar_delay) begin @(posedge M_AXI_ACLK); #1; end
    M_AXI_ARREADY = 1'b1;
    #1;
    who = S1_ARREADY ? 1 : 0;
    n   = int'(M_AXI_ARLEN);
    @(posedge M_AXI_ACLK); #1;
    M_AXI_ARREADY = 1'b0;
    if (who == 1) S1_ARVALID = 1'b0; else S0_ARVALID = 1'b0;
    c = 0;
    b = 0;
    while (b <= n && c < 100) begin
      rr = toggle ? (c % 2 == 0) : 1'b1;
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = dbase + 64'(b);
      M_AXI_RLAST  = (b == n);
      S0_RREADY    = rr;
      S1_RREADY    = rr;
      @(posedge M_AXI_ACLK); #1;
      if (rr) b++;
      c++;
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    S0_RREADY    = 1'b0;
    S1_RREADY    = 1'b0;
  endtask

  task automatic req(input int who, input logic [31:0] addr, input logic [7:0] len);
    if (who == 1) begin S1_ARVALID = 1'b1; S1_ARADDR = addr; S1_ARLEN = len; end
    else          begin S0_ARVALID = 1'b1; S0_ARADDR = addr; S0_ARLEN = len; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b1, t;
    int          exp_g[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    logic [31:0] exp_a[12] = '{32'h100, 32'h200, 32'h180, 32'h280, 32'h4000_0000, 32'h400,
                               32'h300, 32'h500, 32'h600, 32'h700, 32'h800, 32'h900};
    M_AXI_ARESET = 1'b1;
    S0_ARVALID = 0; S0_ARADDR = 0; S0_ARLEN = 0; S0_RREADY = 0;
    S1_ARVALID = 0; S1_ARADDR = 0; S1_ARLEN = 0; S1_RREADY = 0;
    M_AXI_ARREADY = 0; M_AXI_RDATA = 0; M_AXI_RLAST = 0; M_AXI_RVALID = 0;
    repeat (2) @(posedge M_AXI_ACLK);
    #1;
    chk("reset_arvalid", M_AXI_ARVALID, 0);
    chk("reset_rready", M_AXI_RREADY, 0);
    M_AXI_ARESET = 1'b0;

    // Simultaneous pairs straight out of reset: S0, S1, then S0, S1 again.
    req(0, 32'h100, 8'd0); req(1, 32'h200, 8'd0);
    serve(0, 0, 64'h1000, lat);
    serve(0, 0, 64'h2000, lat);
    req(0, 32'h180, 8'd0); req(1, 32'h280, 8'd0);
    serve(0, 0, 64'h1800, lat);
    serve(0, 0, 64'h2800, lat);

    // Single beat to S0, minimum latency.
    req(0, 32'h4000_0000, 8'd0);
    serve(0, 0, 64'hdeadbeef, lat);
    chk("s0_latency", lat, 1);
    chk("s0_beat_data", last_data0, 64'hdeadbeef);
    chk("idle_arvalid", M_AXI_ARVALID, 0);
    chk("idle_rready", M_AXI_RREADY, 0);

    // Tie after S0 was served last: S1 wins.
    req(0, 32'h300, 8'd0); req(1, 32'h400, 8'd0);
    serve(0, 0, 64'h3000, lat);
    serve(0, 0, 64'h4000, lat);

    // Four-beat S1 burst with toggling RREADY.
    b1 = beats1;
    req(1, 32'h500, 8'd3);
    serve(0, 1, 64'h5000, lat);
    chk("s1_burst_beats", beats1 - b1, 4);

    // Downstream holds ARREADY low for 5 cycles.
    req(0, 32'h600, 8'd1);
    serve(5, 0, 64'h6000, lat);

    // Stray downstream beat while idle.
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; S0_RREADY = 1'b1; S1_RREADY = 1'b1;
    repeat (3) begin @(posedge M_AXI_ACLK); #1; end
    chk("stray_rready", M_AXI_RREADY, 0);
    chk("stray_arvalid", M_AXI_ARVALID, 0);
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; S0_RREADY = 1'b0; S1_RREADY = 1'b0;
    req(1, 32'h700, 8'd0);
    serve(0, 0, 64'h7000, lat);

    // Reset between beats 2 and 3 of a 4-beat S0 burst.
    req(0, 32'h800, 8'd3);
    t = 0;
    while (M_AXI_ARVALID !== 1'b1 && t < 30) begin @(posedge M_AXI_ACLK); #1; t++; end
    chk("rst_burst_arvalid", M_AXI_ARVALID, 1);
    M_AXI_ARREADY = 1'b1;
    @(posedge M_AXI_ACLK); #1;
    M_AXI_ARREADY = 1'b0; S0_ARVALID = 1'b0;
    M_AXI_RVALID = 1'b1; S0_RREADY = 1'b1;
    repeat (2) begin @(posedge M_AXI_ACLK); #1; end
    chk("pre_rst_rready", M_AXI_RREADY, 1);
    chk("pre_rst_s0_rvalid", S0_RVALID, 1);
    #1;
    M_AXI_ARESET = 1'b1;
    #1;
    chk("rst_async_rready", M_AXI_RREADY, 0);
    chk("rst_async_s0_rvalid", S0_RVALID, 0);
    chk("rst_async_arvalid", M_AXI_ARVALID, 0);
    M_AXI_RVALID = 1'b0; S0_RREADY = 1'b0;
    req(0, 32'h900, 8'd0);
    @(posedge M_AXI_ACLK); #1;
    M_AXI_ARESET = 1'b0;
    serve(0, 0, 64'h9000, lat);
    chk("post_rst_latency", lat, 1);

    chk("grant_log_size", g_log.size(), 12);
    if (g_log.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("grant_%0d", i), g_log[i], exp_g[i]);
        chk($sformatf("addr_%0d", i), a_log[i], exp_a[i]);
      end
    end

    repeat (2) @(posedge M_AXI_ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_axi_rd_arb.md
PMOD_AXI_RD_ARB -- requirements
Module: pmod_axi_rd_arb

Interface
REQ-001 SHALL have parameter DW, default 64, giving the read data width in bits.
REQ-002 SHALL have port M_AXI_ACLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port M_AXI_ARESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports S0_ARVALID/S1_ARVALID  input  1  read request from requester 0/1.
REQ-005 SHALL have ports S0_ARADDR/S1_ARADDR  input  32  request byte address.
REQ-006 SHALL have ports S0_ARLEN/S1_ARLEN  input  8  burst length minus 1.
REQ-007 SHALL have ports S0_ARREADY/S1_ARREADY  output  1  address accepted for requester 0/1.
REQ-008 SHALL have ports S0_RVALID/S1_RVALID  output  1  read beat valid for requester 0/1.
REQ-009 SHALL have ports S0_RREADY/S1_RREADY  input  1  requester 0/1 accepts a beat.
REQ-010 SHALL have port S_RDATA  output  DW  read data shared by both requesters.
REQ-011 SHALL have port S_RLAST  output  1  last-beat flag shared by both requesters.
REQ-012 SHALL have ports M_AXI_ARADDR 32 / M_AXI_ARLEN 8 / M_AXI_ARVALID 1  output  downstream read address.
REQ-013 SHALL have port M_AXI_ARREADY  input  1  downstream address ready.
REQ-014 SHALL have ports M_AXI_RDATA DW / M_AXI_RLAST 1 / M_AXI_RVALID 1  input  downstream read data.
REQ-015 SHALL have port M_AXI_RREADY  output  1  downstream read ready.

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA, with at most one outstanding burst.
REQ-017 In IDLE with at least one SxARVALID high, SHALL register grant and move to ADDR on the next edge.
REQ-018 When both requesters are pending in IDLE, SHALL grant the requester not served last (round-robin); a lone requester SHALL be granted regardless of history.
REQ-019 In ADDR, SHALL drive M_AXI_ARVALID=1 (registered) and mux M_AXI_ARADDR/M_AXI_ARLEN from the granted requester; requesters hold ARVALID/ARADDR/ARLEN stable until ARREADY.
REQ-020 SHALL drive Sx_ARREADY = (state==ADDR) & (grant==x) & M_AXI_ARREADY, combinationally, for exactly the handshake cycle.
REQ-021 On an ADDR-state ARVALID&ARREADY handshake, SHALL move to DATA on the same edge.
REQ-022 In DATA, SHALL drive Sx_RVALID = M_AXI_RVALID & (grant==x), and M_AXI_RREADY = RREADY of the granted requester; non-granted RVALID SHALL be 0.
REQ-023 SHALL pass S_RDATA=M_AXI_RDATA and S_RLAST=M_AXI_RLAST combinationally in all states.
REQ-024 On a DATA-state beat with RVALID&RREADY&RLAST, SHALL return to IDLE and record the grantee as last-served.
REQ-025 Outside DATA, M_AXI_RREADY and both Sx_RVALID SHALL be 0; stray downstream RVALID SHALL be ignored.
REQ-026 Minimum latency: SxARVALID rising at edge t -> M_AXI_ARVALID high after edge t+1; the next grant issues ARVALID no earlier than 2 edges after the last beat.
REQ-027 A requester whose ARVALID is high during another's burst SHALL wait without loss; it is served next.
REQ-028 ARLEN SHALL be passed through unchanged; beats are counted only by RLAST, not by ARLEN.

Reset
REQ-029 Reset asserted at any time, including mid-burst, SHALL force state=IDLE, M_AXI_ARVALID=0, M_AXI_RREADY=0, all Sx_ARREADY/Sx_RVALID=0, and last-served=1, so requester 0 wins the first tie.
REQ-030 After reset release, the first grant SHALL be possible on the first rising edge.

Verification
REQ-031 S0 ARADDR=0x4000_0000, ARLEN=0, ARREADY=1, one beat RDATA=0xdeadbeef RLAST=1 -> M_AXI_ARADDR=0x4000_0000, S0_ARREADY pulses 1 cycle, S0_RVALID with S_RDATA=0xdeadbeef, S1_RVALID=0, back to IDLE.
REQ-032 S0 and S1 request in the same cycle right after reset (0x100, 0x200) -> S0 is served first, then S1; a second simultaneous pair -> S0 first again only after S1 was served.
REQ-033 S1 request with ARLEN=3, four beats with RREADY toggling 1,0,1,... -> exactly 4 S1 transfers, S1_RVALID follows M_AXI_RVALID, and IDLE is entered only after the RLAST beat.
REQ-034 M_AXI_ARREADY held 0 for 5 cycles in ADDR -> M_AXI_ARVALID stays 1 with a stable address, and S0_ARREADY stays 0 until ARREADY rises.
REQ-035 Reset asserted between beats 2 and 3 of a 4-beat burst -> outputs go to 0 immediately (asynchronous), and the next S0 request is granted normally.
REQ-036 M_AXI_RVALID=1 while in IDLE -> M_AXI_RREADY=0, both Sx_RVALID=0, and the state is unchanged.
